// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, widths, reset defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int PC_W   = 64;
  localparam int INSN_W = 32;

  // Default first fetch address and bubble instruction (addi x0,x0,0).
  localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 64'h0;
  localparam logic [INSN_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  // IDLE: nothing outstanding, buffer empty
  // WAIT: one request outstanding
  // KILL: one request outstanding whose response must be dropped
  // FULL: buffer holds a fetched instruction, nothing outstanding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [PC_W-1:0] align4(input logic [PC_W-1:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, insn} holding register for a response that arrives while IF/ID is stalled.
// Latency: loaded data visible the cycle after load.
// Backpressure: none; the owner never loads while valid. Clear wins over load.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   load, load_pc/insn    capture a pair (sets valid)
//   clear                 drop the held pair
//   valid, held_pc/insn   current contents
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   load_pc,
  input  logic [INSN_W-1:0] load_insn,
  output logic              valid,
  output logic [PC_W-1:0]   held_pc,
  output logic [INSN_W-1:0] held_insn
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid     <= 1'b0;
      held_pc   <= '0;
      held_insn <= NOP_INSN;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      held_pc   <= load_pc;
      held_insn <= load_insn;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one-outstanding imem requests, presents {PC_Out, Instruction} to IF/ID.
// Latency: request in cycle N, response in N+k, pair presented from N+k+1 (no stall).
// Backpressure: stall holds the output; one response is parked in a skid entry and fetching pauses.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   stall                          IF/ID not consuming this cycle
//   branch_taken, branch_target    one-cycle redirect from EX (flushes output, kills in-flight)
//   imem_req, imem_addr            request strobe and word-aligned address
//   imem_valid, imem_rdata         response strobe and instruction word
//   PC_Out, Instruction            registered presented pair
//   fetch_valid                    presented pair is real (0 = bubble)
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   PC_Out,
  output logic [INSN_W-1:0] Instruction,
  output logic              fetch_valid
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;

  // Control decodes
  logic rsp_take;   // response accepted (WAIT, not killed by a same-cycle branch)
  logic buf_load;
  logic buf_clear;

  // Skid entry
  logic              held_valid;
  logic [PC_W-1:0]   held_pc;
  logic [INSN_W-1:0] held_insn;

  // Output register next values
  logic              out_load;
  logic              out_valid_nxt;
  logic [PC_W-1:0]   out_pc_nxt;
  logic [INSN_W-1:0] out_insn_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A redirect suppresses this cycle's request; fetch resumes at the target.
        if (!branch_taken) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (branch_taken && imem_valid) begin
          state_nxt = IDLE;
        end else if (branch_taken) begin
          state_nxt = KILL;
        end else if (imem_valid && !stall) begin
          state_nxt = IDLE;
        end else if (imem_valid) begin
          state_nxt = FULL;
        end
      end
      KILL: begin
        // Further redirects while killing only retarget pc; the stale response
        // still has to be absorbed before a new request may go out.
        if (imem_valid) begin
          state_nxt = IDLE;
        end
      end
      FULL: begin
        if (branch_taken || !stall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // State is IDLE while reset is held, so the request is gated explicitly.
    imem_req  = reset_n && (state == IDLE) && !branch_taken;
    imem_addr = align4(pc);
    // Responses seen in IDLE/FULL are protocol errors and fall out here.
    rsp_take  = (state == WAIT) && imem_valid && !branch_taken;
    buf_load  = rsp_take && stall;
    buf_clear = (state == FULL) && (branch_taken || !stall);
  end

  // ---------------------------------------------------------------------------
  // Program counter: address of the next request
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_nxt = pc;
    if (branch_taken) begin
      pc_nxt = align4(branch_target);
    end else if (rsp_take) begin
      pc_nxt = pc + 64'd4;   // wraps naturally at 2^64
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= align4(RESET_PC);
    end else begin
      pc <= pc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid entry
  // ---------------------------------------------------------------------------
  fetch_skid_buf #(
    .NOP_INSN (NOP_INSN)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pc),
    .load_insn (imem_rdata),
    .valid     (held_valid),
    .held_pc   (held_pc),
    .held_insn (held_insn)
  );

  // ---------------------------------------------------------------------------
  // Output register. Flush beats stall; otherwise load only when consumed.
  // The skid entry is older than any response, so it goes first.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_load      = branch_taken || !stall;
    out_valid_nxt = 1'b0;
    out_pc_nxt    = '0;
    out_insn_nxt  = NOP_INSN;
    if (!branch_taken) begin
      if (held_valid) begin
        out_valid_nxt = 1'b1;
        out_pc_nxt    = held_pc;
        out_insn_nxt  = held_insn;
      end else if (rsp_take) begin
        out_valid_nxt = 1'b1;
        out_pc_nxt    = pc;
        out_insn_nxt  = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PC_Out      <= '0;
      Instruction <= NOP_INSN;
      fetch_valid <= 1'b0;
    end else if (out_load) begin
      PC_Out      <= out_pc_nxt;
      Instruction <= out_insn_nxt;
      fetch_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [63:0] WPC  = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main DUT signals
  logic        reset_n, stall, branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [63:0] pc_out;
  logic [31:0] instruction;
  logic        fetch_valid;

  // Wrap-around DUT signals
  logic        stall2, branch_taken2;
  logic [63:0] branch_target2;
  logic        imem_req2;
  logic [63:0] imem_addr2;
  logic        imem_valid2;
  logic [31:0] imem_rdata2;
  logic [63:0] pc_out2;
  logic [31:0] instruction2;
  logic        fetch_valid2;

  instruction_fetch_unit #(.RESET_PC(64'h0), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .PC_Out(pc_out), .Instruction(instruction), .fetch_valid(fetch_valid)
  );

  instruction_fetch_unit #(.RESET_PC(WPC), .NOP_INSN(NOP)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall(stall2),
    .branch_taken(branch_taken2), .branch_target(branch_target2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
    .PC_Out(pc_out2), .Instruction(instruction2), .fetch_valid(fetch_valid2)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a);
    exp_t e;
    e.pc   = a;
    e.insn = a[31:0];
    sb.push_back(e);
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset(input int lat);
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    mem_lat       = lat;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for every expected pair to be consumed, then freeze fetch.
  task automatic drain(input string name);
    int n;
    n = 0;
    tick();
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    sb.delete();
    stall = 1'b1;
  endtask

  // Instruction memory: one transaction at a time, insn = addr[31:0],
  // response mem_lat cycles after the request cycle.
  initial begin
    bit          pend;
    int          cnt;
    logic [63:0] paddr;
    pend = 0; cnt = 0; paddr = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        chk("one_outstanding", 64'(pend), 64'd0);
        chk("addr_align", {62'd0, imem_addr[1:0]}, 64'd0);
        pend  = 1;
        paddr = imem_addr;
        cnt   = mem_lat;
      end
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_valid = 1'b1;
          imem_rdata = paddr[31:0];
          pend       = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: a pair is consumed at every edge with stall=0 (and no flush).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && fetch_valid && !stall && !branch_taken) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pair: got pc 0x%0h insn 0x%0h, expected none", pc_out, instruction);
        end else begin
          e = sb.pop_front();
          if (pc_out !== e.pc || instruction !== e.insn) begin
            errors++;
            $display("FAIL presented_pair: got pc 0x%0h insn 0x%0h, expected pc 0x%0h insn 0x%0h",
                     pc_out, instruction, e.pc, e.insn);
          end
        end
      end
    end
  end

  // Wrap-around instance: 1-cycle memory, checks the first request addresses.
  logic [63:0] exp2[$] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
  bit          seen2 = 0;
  initial begin
    logic        r2;
    logic [63:0] a2;
    stall2 = 1'b0; branch_taken2 = 1'b0; branch_target2 = '0;
    imem_valid2 = 1'b0; imem_rdata2 = '0;
    forever begin
      @(negedge clk);
      r2 = imem_req2;
      a2 = imem_addr2;
      if (r2 && exp2.size() != 0) chk("wrap_addr", a2, exp2.pop_front());
      if (reset_n && fetch_valid2 && !seen2) begin
        seen2 = 1;
        chk("wrap_first_pc", pc_out2, WPC);
        chk("wrap_first_insn", 64'(instruction2), 64'(WPC[31:0]));
      end
      @(posedge clk);
      #1;
      imem_valid2 = r2;
      imem_rdata2 = a2[31:0];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset values
    @(negedge clk);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_insn", 64'(instruction), 64'(NOP));
    chk("rst_valid", 64'(fetch_valid), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    tick();

    // 1: no stall, 1-cycle memory: 0, 4, 8 with bubbles between
    push(64'h0); push(64'h4); push(64'h8);
    do_reset(1);
    @(negedge clk);
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", imem_addr, 64'h0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t1_bubble_valid", 64'(fetch_valid), 64'd0);
    chk("t1_bubble_pc", pc_out, 64'd0);
    chk("t1_bubble_insn", 64'(instruction), 64'(NOP));
    drain("t1_drain");

    // 2: stall held 5 cycles while response 0x4 arrives
    push(64'h0); push(64'h4); push(64'h8);
    do_reset(1);
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t2_no_req_stalled", 64'(imem_req), 64'd0);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    chk("t2_no_req_full", 64'(imem_req), 64'd0);
    tick();
    @(negedge clk);
    chk("t2_valid", 64'(fetch_valid), 64'd1);
    chk("t2_pc", pc_out, 64'h4);
    chk("t2_req", 64'(imem_req), 64'd1);
    chk("t2_addr", imem_addr, 64'h8);
    drain("t2_drain");

    // 3: redirect to 0x103 while WAIT at 0x10 (3-cycle memory)
    push(64'h100);
    do_reset(3);
    branch_taken = 1'b1; branch_target = 64'h10;
    @(negedge clk);
    chk("t3_req_suppressed", 64'(imem_req), 64'd0);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("t3_req", 64'(imem_req), 64'd1);
    chk("t3_addr", imem_addr, 64'h10);
    tick();
    branch_taken = 1'b1; branch_target = 64'h103;
    @(negedge clk);
    chk("t3_req_during_branch", 64'(imem_req), 64'd0);
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_kill_no_req", 64'(imem_req), 64'd0);
      chk("t3_kill_bubble", 64'(fetch_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("t3_target_req", 64'(imem_req), 64'd1);
    chk("t3_target_addr", imem_addr, 64'h100);
    drain("t3_drain");

    // 4: branch and response in the same cycle with stall=1
    push(64'h200);
    do_reset(1);
    tick(); tick();
    stall = 1'b1;
    @(negedge clk);
    chk("t4_held_valid", 64'(fetch_valid), 64'd1);
    chk("t4_held_pc", pc_out, 64'h0);
    tick();
    branch_taken = 1'b1; branch_target = 64'h200;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", 64'(fetch_valid), 64'd0);
    chk("t4_flush_pc", pc_out, 64'd0);
    chk("t4_flush_insn", 64'(instruction), 64'(NOP));
    chk("t4_req", 64'(imem_req), 64'd1);
    chk("t4_addr", imem_addr, 64'h200);
    drain("t4_drain");

    // 6: reset asserted in WAIT, response lands during reset
    push(64'h0);
    do_reset(3);
    @(negedge clk);
    chk("t6_req0", imem_addr, 64'h0);
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("t6_req4_vld", 64'(imem_req), 64'd1);
    chk("t6_req4", imem_addr, 64'h4);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 64'(fetch_valid), 64'd0);
    chk("t6_rst_pc", pc_out, 64'd0);
    chk("t6_rst_insn", 64'(instruction), 64'(NOP));
    chk("t6_rst_req", 64'(imem_req), 64'd0);
    tick(); tick();
    @(negedge clk);
    chk("t6_rsp_in_rst_req", 64'(imem_req), 64'd0);
    chk("t6_rsp_in_rst_valid", 64'(fetch_valid), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    push(64'h0);
    @(negedge clk);
    chk("t6_release_req", 64'(imem_req), 64'd1);
    chk("t6_release_addr", imem_addr, 64'h0);
    drain("t6_drain");

    // 5: wrap-around instance results
    chk("wrap_done", 64'(exp2.size()), 64'd0);
    chk("wrap_presented", 64'(seen2), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch stage that owns the program counter and issues one-outstanding requests to instruction memory.
- Presents the `PC_Out`/`Instruction` pair consumed by the IF/ID pipeline register, and honours the same `stall` signal that register sees.
- Applies taken-branch redirects from EX, flushing any fetched-but-unconsumed instruction and discarding any in-flight response.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: first fetch address after reset.
- `NOP_INSN`, default 32'h00000013: bubble instruction (`addi x0,x0,0`) presented when `fetch_valid`=0.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: from hazard unit. While high, IF/ID does not consume this block's outputs.
- `branch_taken`, in, 1: one-cycle redirect pulse from EX.
- `branch_target`, in, 64: redirect address. Bits [1:0] are forced to 0 internally.
- `imem_req`, out, 1: request strobe, one cycle per request.
- `imem_addr`, out, 64: request address, valid while `imem_req`=1.
- `imem_valid`, in, 1: response strobe, arriving ≥1 cycle after the request.
- `imem_rdata`, in, 32: response instruction, valid while `imem_valid`=1.
- `PC_Out`, out, 64: address of the presented instruction (registered).
- `Instruction`, out, 32: presented instruction (registered).
- `fetch_valid`, out, 1: presented pair is a real instruction; 0 means bubble.

## Operation
- **Consume rule:** the presented pair is consumed at every posedge where `stall`=0. At that edge the output register loads, in priority order:
  1. the buffered instruction, if any;
  2. otherwise the response arriving this cycle (if not killed);
  3. otherwise a bubble (`PC_Out`=0, `Instruction`=`NOP_INSN`, `fetch_valid`=0).
- **Stall:** with `stall`=1 the output register holds.
- **Buffer:** one entry holding {pc, insn}. The buffer is loaded when a response arrives while `stall`=1.
- **Internal `pc`:** the address of the next request. It advances `pc <= pc + 4` (mod 2^64, wrap to 0) on every accepted, non-killed response.
- **FSM states:**
  - IDLE: no request outstanding, buffer empty.
  - WAIT: request outstanding.
  - KILL: request outstanding, its response must be dropped.
  - FULL: buffer occupied, nothing outstanding.
- **Requests:** `imem_req` = (state==IDLE) && !`branch_taken`, with `imem_addr` = `pc`.
- **IDLE:**
  - `branch_taken` → `pc`=target, stay IDLE.
  - else → WAIT.
- **WAIT:**
  - `branch_taken` && `imem_valid` → drop the response, `pc`=target, go to IDLE.
  - `branch_taken` alone → `pc`=target, go to KILL.
  - `imem_valid` && !`stall` → output loads {`pc`, rdata}, go to IDLE.
  - `imem_valid` && `stall` → buffer loads {`pc`, rdata}, go to FULL.
- **KILL:**
  - `imem_valid` → drop, go to IDLE.
  - `branch_taken` → `pc`=new target, stay KILL.
- **FULL:**
  - `branch_taken` → clear buffer, `pc`=target, go to IDLE.
  - `!stall` → output loads buffer, go to IDLE.
- **Flush:** `branch_taken` forces the output register to bubble at that edge regardless of `stall`. Flush has priority over stall.
- **Invariants:**
  - At most one request is outstanding.
  - The buffer is never written while full.
  - A response received in IDLE or FULL is a protocol error and is ignored.

## Timing
- **Reset (asynchronous, any cycle, including mid-request):**
  - `PC_Out`=0, `Instruction`=`NOP_INSN`, `fetch_valid`=0.
  - `imem_req`=0 during reset; state=IDLE, `pc`=`RESET_PC`, buffer empty.
  - A response to a request issued before reset is ignored because state is IDLE.
- **After reset release:** the first `imem_req` is in the first cycle after `reset_n` rises.
- **Request-to-output latency:** a request in cycle N with `imem_valid` in N+k (k≥1) is presented from cycle N+k+1 when `stall`=0.
- **Throughput:** with k=1 and no stalls, one instruction per 2 cycles.
- **`imem_addr` alignment:** always 4-byte aligned.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum (IDLE/WAIT/KILL/FULL);
  - `NOP_INSN`;
  - `RESET_PC` default;
  - PC width 64 and instruction width 32 constants.
- One natural sub-module: `fetch_skid_buf`, a 1-entry {pc, insn} holding register with valid, load and clear. Everything else stays in the top module.

## Test plan
- **Reset, no stall, 1-cycle memory returning `insn`=addr[31:0]:**
  - the first presented pair is `PC_Out`=0x0 with `fetch_valid`=1;
  - the next pairs are 0x4 and 0x8, with a bubble between each.
- **Stall held 5 cycles while response 0x4 arrives:**
  - FULL is entered, with no new `imem_req` while stalled;
  - 0x4 is presented on the first unstalled edge and not duplicated.
- **`branch_taken` with target 0x103 while WAIT at pc 0x10:**
  - the late response for 0x10 is dropped;
  - the next `imem_addr`=0x100;
  - the output is bubble until 0x100 is presented.
- **`branch_taken` and `imem_valid` in the same cycle, `stall`=1:**
  - the output flushes to bubble and the response is discarded;
  - the next request is at the target.
- **Wrap-around with `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC:**
  - requests go to 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- **`reset_n` asserted in WAIT with the response landing during reset:**
  - outputs are at reset values;
  - the first request after release is at `RESET_PC`.
